// File: rtl/vote3_session_ctrl.sv
// Three-voter session controller: opens a vote window on START, latches the 2-of-3 result
// and holds it for a display period. Optional macro VOTE3_EARLY_END_EN closes the window early.
module vote3_session_ctrl #(
    parameter logic [31:0] WIN_CYC  = 32'd50_000_000,
    parameter logic [31:0] HOLD_CYC = 32'd150_000_000
) (
    input  logic       i_clk_50m,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic       i_key_a,
    input  logic       i_key_b,
    input  logic       i_key_c,
    output logic       o_busy,
    output logic [2:0] o_voted,
    output logic       o_res_vld,
    output logic       o_pass,
    output logic       o_done
);

    localparam int unsigned CNT_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_VOTING = 2'd1,
        ST_RESULT = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               r_start_q;
    logic               r_start_d;
    logic [2:0]         r_key_q;
    logic [2:0]         r_key_d;
    logic [2:0]         r_voted;
    logic [2:0]         w_voted_nxt;
    logic               r_pass;
    logic               w_pass_nxt;
    logic               r_done;
    logic               w_done_nxt;
    logic               r_busy;
    logic               r_res_vld;
    logic               w_start_rise;
    logic [2:0]         w_key_rise;
    logic [2:0]         w_votes;
    logic               w_maj;
    logic               w_early;
    logic               w_win_end;
    logic               w_hold_end;

    // Input register plus delay register; delay resets low so a held key/START counts once after reset.
    always_ff @(posedge i_clk_50m) begin
        if (i_rst) begin
            r_start_q <= 1'b0;
            r_start_d <= 1'b0;
            r_key_q   <= 3'b000;
            r_key_d   <= 3'b000;
        end else begin
            r_start_q <= i_start;
            r_start_d <= r_start_q;
            r_key_q   <= {i_key_a, i_key_b, i_key_c};
            r_key_d   <= r_key_q;
        end
    end

    assign w_start_rise = r_start_q & ~r_start_d;
    assign w_key_rise   = r_key_q & ~r_key_d;

    // Votes including any rise captured this very cycle.
    assign w_votes    = r_voted | w_key_rise;
    assign w_maj      = (w_votes[2] & w_votes[1]) | (w_votes[2] & w_votes[0]) | (w_votes[1] & w_votes[0]);
    assign w_win_end  = (r_cnt == WIN_CYC - 32'd1);
    assign w_hold_end = (r_cnt == HOLD_CYC - 32'd1);

`ifdef VOTE3_EARLY_END_EN
    // Two yes votes already decide the outcome.
    assign w_early = w_maj;
`else
    assign w_early = 1'b0;
`endif

    always_ff @(posedge i_clk_50m) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_voted   <= 3'b000;
            r_pass    <= 1'b0;
            r_done    <= 1'b0;
            r_busy    <= 1'b0;
            r_res_vld <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_voted   <= w_voted_nxt;
            r_pass    <= w_pass_nxt;
            r_done    <= w_done_nxt;
            r_busy    <= (w_state_nxt != ST_IDLE);
            r_res_vld <= (w_state_nxt == ST_RESULT);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_voted_nxt = r_voted;
        w_pass_nxt  = r_pass;
        w_done_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt   = '0;
                w_voted_nxt = 3'b000;
                w_pass_nxt  = 1'b0;
                if (w_start_rise) begin
                    w_state_nxt = ST_VOTING;
                end
            end
            ST_VOTING: begin
                w_voted_nxt = w_votes;
                w_cnt_nxt   = CNT_W'(r_cnt + 32'd1);
                if (w_win_end || w_early) begin
                    w_state_nxt = ST_RESULT;
                    w_cnt_nxt   = '0;
                    w_pass_nxt  = w_maj;
                    w_done_nxt  = 1'b1;
                end
            end
            ST_RESULT: begin
                w_cnt_nxt = CNT_W'(r_cnt + 32'd1);
                if (w_hold_end) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                    w_voted_nxt = 3'b000;
                    w_pass_nxt  = 1'b0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
                w_voted_nxt = 3'b000;
                w_pass_nxt  = 1'b0;
            end
        endcase
    end

    assign o_busy    = r_busy;
    assign o_voted   = r_voted;
    assign o_res_vld = r_res_vld;
    assign o_pass    = r_pass;
    assign o_done    = r_done;

endmodule

// File: tb/tb_vote3_session_ctrl.sv
// Directed bench for vote3_session_ctrl with WIN_CYC=20, HOLD_CYC=10.
module tb_vote3_session_ctrl;

    localparam int WIN  = 20;
    localparam int HOLD = 10;
    localparam int NONE = 999;

    logic       clk;
    logic       rst;
    logic       start;
    logic       key_a;
    logic       key_b;
    logic       key_c;
    logic       busy;
    logic [2:0] voted;
    logic       res_vld;
    logic       pass;
    logic       done;

    int n_checks = 0;
    int n_errors = 0;

    vote3_session_ctrl #(
        .WIN_CYC (32'd20),
        .HOLD_CYC(32'd10)
    ) u_dut (
        .i_clk_50m(clk),
        .i_rst    (rst),
        .i_start  (start),
        .i_key_a  (key_a),
        .i_key_b  (key_b),
        .i_key_c  (key_c),
        .o_busy   (busy),
        .o_voted  (voted),
        .o_res_vld(res_vld),
        .o_pass   (pass),
        .o_done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] flags();
        return {busy, res_vld, pass, done};
    endfunction

    // r* = window cycle in which that input's rise is seen (input driven high one cycle earlier).
    task automatic run_session(input string name, input int ra, input int rb, input int rc,
                               input int rs, input logic [2:0] exp_voted, input logic exp_pass,
                               input int exp_win);
        logic [2:0] ev;
        logic [3:0] ef;
        start = 1'b1;
        tick();
        start = 1'b0;
        check({name, ":idle_before"}, 32'(busy), 32'd0);
        tick();
        check({name, ":busy_on"}, 32'(busy), 32'd1);
        for (int i = 0; i <= exp_win + HOLD; i++) begin
            key_a = (i == ra - 1);
            key_b = (i == rb - 1);
            key_c = (i == rc - 1);
            start = (i == rs - 1);
            if (i < exp_win) begin
                ev = {ra < i, rb < i, rc < i};
                ef = 4'b1000;
            end else if (i < exp_win + HOLD) begin
                ev = exp_voted;
                ef = {1'b1, 1'b1, exp_pass, i == exp_win};
            end else begin
                ev = 3'b000;
                ef = 4'b0000;
            end
            check($sformatf("%s:flags@%0d", name, i), 32'(flags()), 32'(ef));
            check($sformatf("%s:voted@%0d", name, i), 32'(voted), 32'(ev));
            tick();
        end
        key_a = 1'b0;
        key_b = 1'b0;
        key_c = 1'b0;
        start = 1'b0;
        tick();
        tick();
        tick();
        check({name, ":stays_idle"}, 32'(flags()), 32'd0);
    endtask

    initial begin
        int n_busy;
        int early_w1;
        int early_w4;
`ifdef VOTE3_EARLY_END_EN
        early_w1 = 8;
        early_w4 = 6;
`else
        early_w1 = WIN;
        early_w4 = WIN;
`endif
        rst   = 1'b1;
        start = 1'b0;
        key_a = 1'b0;
        key_b = 1'b0;
        key_c = 1'b0;

        // Reset held with keys toggling.
        for (int i = 0; i < 3; i++) begin
            key_a = ~key_a;
            key_c = ~key_c;
            tick();
            check($sformatf("rst_flags@%0d", i), 32'(flags()), 32'd0);
            check($sformatf("rst_voted@%0d", i), 32'(voted), 32'd0);
        end
        key_a = 1'b0;
        key_c = 1'b0;
        rst   = 1'b0;
        tick();
        tick();

        // Key press in IDLE is ignored.
        key_a = 1'b1;
        tick();
        key_a = 1'b0;
        tick();
        tick();
        tick();
        check("idle_key_voted", 32'(voted), 32'd0);
        check("idle_key_flags", 32'(flags()), 32'd0);

        run_session("maj", 3, NONE, 7, 10, 3'b101, 1'b1, early_w1);
        run_session("single", NONE, 4, NONE, WIN + HOLD - 1, 3'b010, 1'b0, WIN);
        run_session("boundary", 19, 19, 20, NONE, 3'b110, 1'b1, WIN);
        run_session("early", NONE, 2, 5, NONE, 3'b011, 1'b1, early_w4);

        // Mid-session reset during RESULT, START held through reset release.
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        key_a = 1'b1;
        key_b = 1'b1;
        tick();
        key_a = 1'b0;
        key_b = 1'b0;
        for (int i = 0; i < 40 && !res_vld; i++) tick();
        check("mid_res_vld", 32'(res_vld), 32'd1);
        check("mid_pass", 32'(pass), 32'd1);
        tick();
        rst   = 1'b1;
        start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("mid_rst_flags@%0d", i), 32'(flags()), 32'd0);
            check($sformatf("mid_rst_voted@%0d", i), 32'(voted), 32'd0);
        end
        rst = 1'b0;
        tick();
        check("restart_not_yet", 32'(busy), 32'd0);
        tick();
        check("restart_busy", 32'(busy), 32'd1);
        n_busy = 0;
        for (int i = 0; i < 100 && busy; i++) begin
            n_busy++;
            tick();
        end
        check("restart_busy_len", 32'(n_busy), 32'(WIN + HOLD));
        for (int i = 0; i < 6; i++) tick();
        check("restart_single_session", 32'(flags()), 32'd0);
        start = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
